// File: rtl/spi_cmd_decoder_if.sv
// Byte-stream and register-file signals between the SPI front-end, the command
// decoder and the register file.
interface spi_cmd_decoder_if #(
    parameter int ADDR_W = 6
);
    logic              cs_n;
    logic              byte_sync;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic [ADDR_W-1:0] reg_addr;
    logic              reg_hi;
    logic              reg_wr;
    logic [7:0]        reg_wdata;
    logic              reg_rd;
    logic [7:0]        reg_rdata;
    logic              proto_err;

    modport master (
        output cs_n, byte_sync, data_in, reg_rdata,
        input  data_out, reg_addr, reg_hi, reg_wr, reg_wdata, reg_rd, proto_err
    );

    modport slave (
        input  cs_n, byte_sync, data_in, reg_rdata,
        output data_out, reg_addr, reg_hi, reg_wr, reg_wdata, reg_rd, proto_err
    );
endinterface

// File: rtl/spi_cmd_decoder.sv
// Turns the SPI received-byte stream into 2-byte command frames: register
// write/read strobes, with read data returned on data_out for MISO.
module spi_cmd_decoder #(
    parameter int ADDR_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_cmd_decoder_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        RD_ISSUE,
        RD_CAP,
        RD_DUMMY
    } state_t;

    state_t            state, state_nxt;
    logic              cs_meta, cs_s, cs_d;
    logic              cmd_take, wr_take, err_hit, frame_start;
    logic [ADDR_W-1:0] addr_q;
    logic              hi_q;
    logic              wr_q;
    logic              perr_q;
    logic [7:0]        wdata_q;
    logic [7:0]        rdata_q;
    logic [7:0]        data_out_q;

    // cs_n is asynchronous to clk; synchronizer idles deasserted (high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_meta <= 1'b1;
            cs_s    <= 1'b1;
            cs_d    <= 1'b1;
        end else begin
            cs_meta <= bus.cs_n;
            cs_s    <= cs_meta;
            cs_d    <= cs_s;
        end
    end

    assign frame_start = cs_d & ~cs_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // A deasserted frame overrides everything, including a coincident byte.
    always_comb begin
        state_nxt = state;
        cmd_take  = 1'b0;
        wr_take   = 1'b0;
        err_hit   = 1'b0;
        if (cs_s) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.byte_sync) begin
                        cmd_take  = 1'b1;
                        state_nxt = bus.data_in[7] ? WDATA : RD_ISSUE;
                    end
                end
                WDATA: begin
                    if (bus.byte_sync) begin
                        wr_take   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                RD_ISSUE: begin
                    err_hit   = bus.byte_sync;
                    state_nxt = RD_CAP;
                end
                RD_CAP: begin
                    err_hit   = bus.byte_sync;
                    state_nxt = RD_DUMMY;
                end
                RD_DUMMY: begin
                    if (bus.byte_sync) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            hi_q       <= 1'b0;
            wdata_q    <= 8'h00;
            wr_q       <= 1'b0;
            rdata_q    <= 8'h00;
            data_out_q <= 8'h00;
            perr_q     <= 1'b0;
        end else begin
            if (cmd_take) begin
                addr_q <= bus.data_in[ADDR_W-1:0];
                hi_q   <= bus.data_in[6];
            end
            if (wr_take) wdata_q <= bus.data_in;
            wr_q <= wr_take;
            // Register-file data is combinational; register it in the strobe cycle.
            if (state == RD_ISSUE) rdata_q <= bus.reg_rdata;
            if (state == RD_CAP && !cs_s) data_out_q <= rdata_q;
            if (frame_start)  perr_q <= 1'b0;
            else if (err_hit) perr_q <= 1'b1;
        end
    end

    assign bus.reg_addr  = addr_q;
    assign bus.reg_hi    = hi_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_wr    = wr_q;
    assign bus.reg_rd    = (state == RD_ISSUE) && !cs_s;
    assign bus.data_out  = data_out_q;
    assign bus.proto_err = perr_q;
endmodule
